// File: rtl/synth_pkg.sv
// ============================================================================
// Module      : synth_pkg
// Description : Constants and key-vector type shared by the synthesizer blocks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package synth_pkg;
    localparam int NUM_KEYS       = 17;
    localparam int NOTE_W         = 5;
    localparam int TICK_DIV       = 100;
    localparam int STABLE_SAMPLES = 4;

    typedef logic [NUM_KEYS-1:0] key_vec_t;
endpackage

`default_nettype wire

// File: rtl/key_debounce_cell.sv
// ============================================================================
// Module      : key_debounce_cell
// Description : Per-key 2-flop synchronizer, sample shift register and
//               hysteresis output flop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_debounce_cell #(
    parameter int STABLE_SAMPLES = synth_pkg::STABLE_SAMPLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic tick,
    input  logic key_in,
    output logic key_db
);

    logic                      r_sync1;
    logic                      r_sync2;
    logic [STABLE_SAMPLES-1:0] r_shreg;
    logic                      r_db;
    logic [STABLE_SAMPLES-1:0] w_shreg_next;

    assign w_shreg_next = {r_shreg[STABLE_SAMPLES-2:0], r_sync2};

    // Output only moves on a unanimous window; mixed windows hold the old level.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_shreg <= '0;
            r_db    <= 1'b0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
            if (tick) begin
                r_shreg <= w_shreg_next;
                if (&w_shreg_next) begin
                    r_db <= 1'b1;
                end else if (~|w_shreg_next) begin
                    r_db <= 1'b0;
                end
            end
        end
    end

    assign key_db = r_db;

endmodule

`default_nettype wire

// File: rtl/key_debounce_encoder.sv
// ============================================================================
// Module      : key_debounce_encoder
// Description : Debounces the raw key inputs for the synthesizer gpio and
//               reports the highest pressed key as a registered note index.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_debounce_encoder #(
    parameter int NUM_KEYS       = synth_pkg::NUM_KEYS,
    parameter int NOTE_W         = synth_pkg::NOTE_W,
    parameter int TICK_DIV       = synth_pkg::TICK_DIV,
    parameter int STABLE_SAMPLES = synth_pkg::STABLE_SAMPLES
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cs,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_db,
    output logic [NOTE_W-1:0]   note_idx,
    output logic                note_valid,
    output logic                note_changed
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0]    r_cnt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_db;
    logic [NOTE_W-1:0]   w_idx;
    logic                w_valid;
    logic [NOTE_W-1:0]   r_idx;
    logic                r_valid;
    logic                r_changed;

    assign w_tick = !cs && (r_cnt == CNT_W'(TICK_DIV - 1));

    // Holding the count at zero while deselected restarts the sample phase cleanly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (cs || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_debounce_cell #(
                .STABLE_SAMPLES (STABLE_SAMPLES)
            ) u_cell (
                .clk    (clk),
                .nrst   (nrst),
                .tick   (w_tick),
                .key_in (keys_in[i]),
                .key_db (w_db[i])
            );
        end
    endgenerate

    always_comb begin
        w_idx   = '0;
        w_valid = |w_db;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_db[i]) begin
                w_idx = NOTE_W'(i);
            end
        end
    end

    // The change strobe compares the incoming encoding with the registered one,
    // so it rises together with the updated note outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_idx     <= w_idx;
            r_valid   <= w_valid;
            r_changed <= !cs && ({w_valid, w_idx} != {r_valid, r_idx});
        end
    end

    assign keys_db      = w_db;
    assign note_idx     = r_idx;
    assign note_valid   = r_valid;
    assign note_changed = r_changed;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_encoder.sv
// ============================================================================
// Module      : tb_key_debounce_encoder
// Description : Directed bench for key_debounce_encoder with a note scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_debounce_encoder;

    localparam int NK = 17;
    localparam int NW = 5;
    localparam logic [NK-1:0] ALL = 17'h1FFFF;

    logic          clk;
    logic          nrst;
    logic          cs;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] keys_db;
    logic [NW-1:0] note_idx;
    logic          note_valid;
    logic          note_changed;

    int n_vec = 0;
    int n_err = 0;
    logic [NW:0] sb[$];

    key_debounce_encoder #(
        .NUM_KEYS       (NK),
        .NOTE_W         (NW),
        .TICK_DIV       (4),
        .STABLE_SAMPLES (3)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .cs           (cs),
        .keys_in      (keys_in),
        .keys_db      (keys_db),
        .note_idx     (note_idx),
        .note_valid   (note_valid),
        .note_changed (note_changed)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_db(input logic [NK-1:0] mask, input logic [NK-1:0] val,
                           input int min_c, input int max_c, input string name);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 1; k <= max_c; k++) begin
            @(negedge clk);
            if ((keys_db & mask) === val) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: keys_db=%h, expected %h within %0d cycles", name, keys_db & mask, val, max_c);
        end else if (k < min_c) begin
            n_err++;
            $display("FAIL %s: keys_db reached %h at cycle %0d, expected not before %0d", name, val, k, min_c);
        end
    endtask

    // Scoreboard monitor: every strobe must match the next queued {valid, idx}.
    initial begin
        logic [NW:0] exp;
        forever begin
            @(negedge clk);
            if (nrst && note_changed) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL note_changed: unexpected pulse with valid=%b idx=%0d, expected no pulse",
                             note_valid, note_idx);
                end else begin
                    exp = sb.pop_front();
                    if ({note_valid, note_idx} !== exp) begin
                        n_err++;
                        $display("FAIL note_pulse: valid=%b idx=%0d, expected valid=%b idx=%0d",
                                 note_valid, note_idx, exp[NW], exp[NW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        bit ok;
        nrst    = 1'b0;
        cs      = 1'b0;
        keys_in = ALL;

        // Reset with all keys held
        #10;
        nrst = 1'b1;
        #1;
        check("rst_keys_db", 32'(keys_db), 32'h0);
        check("rst_note_idx", 32'(note_idx), 32'h0);
        check("rst_note_valid", 32'(note_valid), 32'h0);
        check("rst_note_changed", 32'(note_changed), 32'h0);
        sb.push_back({1'b1, 5'd16});
        wait_db(ALL, ALL, 10, 15, "reset_db");

        // Single press of key 12
        keys_in = 17'h01000;
        sb.push_back({1'b1, 5'd12});
        wait_db(ALL, 17'h01000, 10, 15, "press_db");
        @(negedge clk);
        check("press_note", 32'({note_valid, note_idx}), 32'({1'b1, 5'd12}));

        // Bounce on key 0, 3-cycle pulses
        ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c % 3 == 0) keys_in[0] = ~keys_in[0];
            @(negedge clk);
            if (keys_db[0] !== 1'b0) ok = 1'b0;
        end
        check("bounce_reject", 32'(ok), 32'h1);
        keys_in[0] = 1'b1;
        wait_db(17'h00001, 17'h00001, 0, 15, "bounce_settle");

        // Priority and release
        keys_in = 17'h00001;
        sb.push_back({1'b1, 5'd0});
        wait_db(ALL, 17'h00001, 10, 15, "release12_db");
        keys_in = 17'h10001;
        sb.push_back({1'b1, 5'd16});
        wait_db(ALL, 17'h10001, 10, 15, "prio_db");
        @(negedge clk);
        check("prio_note", 32'({note_valid, note_idx}), 32'({1'b1, 5'd16}));
        keys_in = 17'h00001;
        sb.push_back({1'b1, 5'd0});
        wait_db(ALL, 17'h00001, 10, 15, "drop16_db");
        keys_in = 17'h00000;
        sb.push_back({1'b0, 5'd0});
        wait_db(ALL, 17'h00000, 10, 15, "drop0_db");
        @(negedge clk);
        check("drop0_note", 32'({note_valid, note_idx}), 32'h0);

        // Chip select freeze
        keys_in = 17'h00010;
        sb.push_back({1'b1, 5'd4});
        wait_db(ALL, 17'h00010, 10, 15, "cs_setup_db");
        @(negedge clk);
        cs      = 1'b1;
        keys_in = 17'h00000;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (keys_db !== 17'h00010 || note_idx !== 5'd4 || note_valid !== 1'b1 || note_changed !== 1'b0)
                ok = 1'b0;
        end
        check("cs_hold", 32'(ok), 32'h1);
        cs = 1'b0;
        sb.push_back({1'b0, 5'd0});
        wait_db(ALL, 17'h00000, 1, 13, "cs_resume_db");
        @(negedge clk);

        // Reset while key 5 is held
        keys_in = 17'h00020;
        sb.push_back({1'b1, 5'd5});
        wait_db(ALL, 17'h00020, 10, 15, "k5_db");
        @(negedge clk);
        #20;
        nrst = 1'b0;
        #1;
        check("midrst_keys_db", 32'(keys_db), 32'h0);
        check("midrst_note", 32'({note_valid, note_idx}), 32'h0);
        #10;
        nrst = 1'b1;
        sb.push_back({1'b1, 5'd5});
        wait_db(ALL, 17'h00020, 10, 15, "k5_return_db");
        repeat (4) @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
